// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: data/address widths,
// sequential PC step and the reset fetch address.
package instruction_fetch_unit_pkg;
    localparam int IFU_DW       = 20;
    localparam int IFU_AW       = 20;
    localparam int PC_INC       = 4;
    localparam int IFU_RESET_PC = 0;
endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Prefetch FIFO of {pc, ins} entries with synchronous flush; the head entry
// is always driven on dout, and pops on an empty queue are ignored.
module fetch_queue
    import instruction_fetch_unit_pkg::*;
#(
    parameter int W     = IFU_AW + IFU_DW,
    parameter int DEPTH = 2
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [W-1:0]                 dout
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic                    do_pop;

    assign do_pop = pop && (count != '0);
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, issues 1-cycle-latency memory reads with
// queue-slot credits, buffers responses and redirects on taken branches.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int            DW       = IFU_DW,
    parameter int            AW       = IFU_AW,
    parameter int            DEPTH    = 2,
    parameter logic [AW-1:0] RESET_PC = AW'(IFU_RESET_PC)
)(
    input  logic          clk,
    input  logic          rst_n,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          branch,
    input  logic          zero,
    input  logic [AW-1:0] imm,
    input  logic [AW-1:0] br_pc,
    output logic          ins_valid,
    input  logic          ins_ready,
    output logic [DW-1:0] ins,
    output logic [AW-1:0] ins_pc
);
    localparam int CW = $clog2(DEPTH+1);

    logic          take;
    logic [AW-1:0] pc;
    logic [AW-1:0] req_pc;
    logic [AW-1:0] target;
    logic          inflight;
    logic [CW-1:0] count;
    logic [CW:0]   credits;
    logic          push;
    logic          pop;
    logic [AW+DW-1:0] head;

    assign take   = branch && zero;
    assign target = br_pc + AW'(PC_INC) + imm;

    // An outstanding read already owns a queue slot, so a push never overflows.
    assign credits   = {1'b0, count} + (CW+1)'(inflight);
    assign mem_rd_en = rst_n && !take && (credits < (CW+1)'(DEPTH));
    assign mem_addr  = pc;

    assign ins_valid = (count != '0);
    assign push      = inflight && !take;
    assign pop       = ins_valid && ins_ready && !take;
    assign ins_pc    = head[AW+DW-1:DW];
    assign ins       = head[DW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (take) begin
            pc       <= {target[AW-1:2], 2'b00};
            inflight <= 1'b0;
        end else if (mem_rd_en) begin
            pc       <= pc + AW'(PC_INC);
            req_pc   <= pc;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_queue #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({req_pc, mem_rdata}),
        .pop   (pop),
        .flush (take),
        .count (count),
        .dout  (head)
    );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: hand-derived vector table, hand sequences
// for stall/async reset, and a randomized run against a queue-level model.
module tb_instruction_fetch_unit;
    localparam int DW    = 20;
    localparam int AW    = 20;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          branch = 1'b0;
    logic          zero = 1'b0;
    logic [AW-1:0] imm = '0;
    logic [AW-1:0] br_pc = '0;
    logic          ins_valid;
    logic          ins_ready = 1'b0;
    logic [DW-1:0] ins;
    logic [AW-1:0] ins_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .RESET_PC(20'h00000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .branch(branch), .zero(zero), .imm(imm), .br_pc(br_pc),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .ins_pc(ins_pc)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 20'h0) return 20'h00AAA;
        if (a == 20'h4) return 20'h00BBB;
        return a ^ 20'h5A5A5;
    endfunction

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk)
        if (mem_rd_en) mem_rdata <= mem_word(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: prefetch queue, outstanding-read list and PC.
    logic [AW-1:0] q_pc[$];
    logic [DW-1:0] q_ins[$];
    logic [AW-1:0] pend[$];
    logic [AW-1:0] m_pc;

    function automatic void m_reset();
        q_pc.delete(); q_ins.delete(); pend.delete();
        m_pc = 20'h0;
    endfunction

    task automatic m_check();
        logic exp_rd;
        exp_rd = !(branch && zero) && (q_pc.size() + pend.size() < DEPTH);
        chk("rnd_rd_en", 32'(mem_rd_en), 32'(exp_rd));
        if (exp_rd) chk("rnd_addr", 32'(mem_addr), 32'(m_pc));
        chk("rnd_valid", 32'(ins_valid), 32'(q_pc.size() != 0));
        if (q_pc.size() != 0) begin
            chk("rnd_ins", 32'(ins), 32'(q_ins[0]));
            chk("rnd_ins_pc", 32'(ins_pc), 32'(q_pc[0]));
        end
    endtask

    function automatic void m_edge();
        logic          issue;
        logic [AW-1:0] t;
        if (branch && zero) begin
            q_pc.delete(); q_ins.delete(); pend.delete();
            t = br_pc + 20'd4 + imm;
            t[1:0] = 2'b00;
            m_pc = t;
        end else begin
            issue = (q_pc.size() + pend.size() < DEPTH);
            if (q_pc.size() != 0 && ins_ready) begin
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            if (pend.size() != 0) begin
                q_pc.push_back(pend[0]);
                q_ins.push_back(mem_word(pend[0]));
                pend.delete();
            end
            if (issue) begin
                pend.push_back(m_pc);
                m_pc = m_pc + 20'd4;
            end
        end
    endfunction

    typedef struct {
        logic          ready, br, zr;
        logic [AW-1:0] imm_v, brpc_v;
        logic          rd;
        logic [AW-1:0] addr;
        logic          vld;
        logic [DW-1:0] ins_v;
        logic [AW-1:0] ipc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic b, input logic z,
                                input logic [AW-1:0] im, input logic [AW-1:0] bp,
                                input logic rd, input logic [AW-1:0] ad,
                                input logic v, input logic [DW-1:0] iv,
                                input logic [AW-1:0] ip);
        vec_t x;
        x.ready = r; x.br = b; x.zr = z; x.imm_v = im; x.brpc_v = bp;
        x.rd = rd; x.addr = ad; x.vld = v; x.ins_v = iv; x.ipc = ip;
        return x;
    endfunction

    vec_t vt[10];
    logic [AW-1:0] seen[$];

    initial begin
        // Cycle-by-cycle from reset release, ready=1: fall-through branch in
        // rows 3-4, taken branch (br_pc=8, imm=12 -> 24) with a pending read in row 5.
        vt[0] = mk(1'b1, 1'b0, 1'b0, 20'd0,  20'd0, 1'b1, 20'd0,  1'b0, 20'h0,        20'd0);
        vt[1] = mk(1'b1, 1'b0, 1'b0, 20'd0,  20'd0, 1'b1, 20'd4,  1'b0, 20'h0,        20'd0);
        vt[2] = mk(1'b1, 1'b0, 1'b0, 20'd0,  20'd0, 1'b0, 20'd0,  1'b1, 20'h00AAA,    20'd0);
        vt[3] = mk(1'b1, 1'b1, 1'b0, 20'd12, 20'd0, 1'b1, 20'd8,  1'b1, 20'h00BBB,    20'd4);
        vt[4] = mk(1'b1, 1'b1, 1'b0, 20'd12, 20'd0, 1'b1, 20'd12, 1'b0, 20'h0,        20'd0);
        vt[5] = mk(1'b1, 1'b1, 1'b1, 20'd12, 20'd8, 1'b0, 20'd0,  1'b1, mem_word(8),  20'd8);
        vt[6] = mk(1'b1, 1'b0, 1'b0, 20'd0,  20'd0, 1'b1, 20'd24, 1'b0, 20'h0,        20'd0);
        vt[7] = mk(1'b1, 1'b0, 1'b0, 20'd0,  20'd0, 1'b1, 20'd28, 1'b0, 20'h0,        20'd0);
        vt[8] = mk(1'b1, 1'b0, 1'b0, 20'd0,  20'd0, 1'b0, 20'd0,  1'b1, mem_word(24), 20'd24);
        vt[9] = mk(1'b1, 1'b0, 1'b0, 20'd0,  20'd0, 1'b1, 20'd32, 1'b1, mem_word(28), 20'd28);

        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(ins_valid), 32'd0);
        chk("reset_rd_en", 32'(mem_rd_en), 32'd0);
        chk("reset_ins", 32'(ins), 32'd0);
        chk("reset_ins_pc", 32'(ins_pc), 32'd0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            ins_ready = vt[i].ready; branch = vt[i].br; zero = vt[i].zr;
            imm = vt[i].imm_v; br_pc = vt[i].brpc_v;
            #1;
            chk($sformatf("vec%0d_rd_en", i), 32'(mem_rd_en), 32'(vt[i].rd));
            if (vt[i].rd) chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vt[i].addr));
            chk($sformatf("vec%0d_valid", i), 32'(ins_valid), 32'(vt[i].vld));
            if (vt[i].vld) begin
                chk($sformatf("vec%0d_ins", i), 32'(ins), 32'(vt[i].ins_v));
                chk($sformatf("vec%0d_ins_pc", i), 32'(ins_pc), 32'(vt[i].ipc));
            end
        end

        // Asynchronous reset between edges while an instruction is presented.
        @(negedge clk);
        branch = 1'b0; zero = 1'b0; ins_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(ins_valid), 32'd0);
        chk("async_rst_rd_en", 32'(mem_rd_en), 32'd0);

        // Stall from reset: exactly two reads, then hold until decode accepts.
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (mem_rd_en) seen.push_back(mem_addr);
            @(negedge clk);
        end
        chk("stall_reads", 32'(seen.size()), 32'd2);
        if (seen.size() >= 2) begin
            chk("stall_addr0", 32'(seen[0]), 32'd0);
            chk("stall_addr1", 32'(seen[1]), 32'd4);
        end
        ins_ready = 1'b1;
        #1;
        chk("stall_hold_rd", 32'(mem_rd_en), 32'd0);
        chk("stall_head_pc", 32'(ins_pc), 32'd0);
        chk("stall_head_ins", 32'(ins), 32'h00AAA);
        @(negedge clk);
        #1;
        chk("resume_rd", 32'(mem_rd_en), 32'd1);
        chk("resume_addr", 32'(mem_addr), 32'd8);
        chk("resume_head_pc", 32'(ins_pc), 32'd4);

        // Randomized run against the model, with one async reset mid-stream.
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 600; i++) begin
            ins_ready = ($urandom_range(0, 3) != 0);
            branch    = ($urandom_range(0, 7) == 0);
            zero      = $urandom_range(0, 1) == 1;
            imm       = AW'($urandom);
            br_pc     = AW'($urandom);
            #1;
            m_check();
            @(posedge clk);
            m_edge();
            if (i == 300) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rnd_rst_valid", 32'(ins_valid), 32'd0);
                chk("rnd_rst_rd_en", 32'(mem_rd_en), 32'd0);
                m_reset();
                @(negedge clk);
                rst_n = 1'b1;
                branch = 1'b0;
                #1;
                chk("rnd_restart_addr", 32'(mem_addr), 32'd0);
                chk("rnd_restart_rd", 32'(mem_rd_en), 32'd1);
                @(posedge clk);
                m_edge();
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
